mmio_io_ctrl: RTL
=================

Name: mmio_io_ctrl

Overview:
Parametrised memory-mapped IO controller behind the LSU IO region of the single-cycle core. It is the next generation of the fixed LED/HEX/LCD/switch/button register bank, with:
- a configurable number of HEX digits, buttons and switch bits;
- synchronised and debounced buttons with press-edge capture;
- a programmable interval timer;
- a combined interrupt output.

Reads are combinational so a load completes in one core cycle; writes commit on the clock edge.

Parameters:
ADDR_W, 8, byte-offset width inside the IO region
NUM_HEX, 8, seven-segment digits driven (1..8)
NUM_BTN, 4, push buttons (1..8)
SW_W, 32, switch input width (1..32)
DB_CYCLES, 4, consecutive stable cycles required to accept a button change (>=1)
SYNC_STAGES, 2, synchroniser flops on i_io_sw and i_io_btn (>=2)

Ports:
i_clk  in  1  system clock, all state on rising edge
i_rst  in  1  synchronous reset, active-high
i_addr  in  ADDR_W  byte offset; bits [1:0] ignored (word access)
i_wdata  in  32  store data
i_bmask  in  4  byte enables for stores, bit n = byte n
i_wren  in  1  store strobe, one cycle per store
o_rdata  out  32  combinational read data for i_addr
i_io_sw  in  SW_W  raw switches
i_io_btn  in  NUM_BTN  raw buttons, 1 = pressed
o_io_ledr  out  32  red LEDs
o_io_ledg  out  32  green LEDs
o_io_lcd  out  32  LCD control/data word
o_io_hex  out  NUM_HEX*7  digit k on bits [7k+6:7k]
o_irq  out  1  level interrupt

Behaviour:
Reset and bus
- Reset is synchronous and active-high. Every register, synchroniser flop, debounce counter and output is 0 on the first edge with i_rst=1.
- If i_rst and i_wren are high on the same edge, reset wins and the write is dropped.
- Writes commit on the edge with i_wren=1, honouring i_bmask per byte.
- Reads return pre-write state in the same cycle.
- Unmapped offsets read 0; writes to them are ignored. Read-only registers ignore writes.

Register map (byte offset)
- 0x00 LEDR, R/W, 32 bit.
- 0x04 LEDG, R/W, 32 bit.
- 0x08 HEXLO: byte k holds digit k (k=0..3), only bits [6:0] are stored and bit 7 reads 0.
- 0x0C HEXHI: digits 4..7, same layout.
- In HEXLO and HEXHI, digits at index >= NUM_HEX read 0 and are not stored.
- 0x10 LCD, R/W, 32 bit.
- 0x14 SW, RO: synchronised switches, zero-extended to 32 bits.
- 0x18 BTN, RO: debounced button state in bits [NUM_BTN-1:0].
- 0x1C BTNEDGE, W1C: sticky press flags.
- 0x20 TCOUNT, R/W: timer count.
- 0x24 TCMP, R/W: timer compare value.
- 0x28 TCTRL:
  - bit0 en;
  - bit1 auto_reload;
  - bit2 timer irq_en;
  - bit3 match flag, W1C;
  - bits [8+NUM_BTN-1:8] per-button irq enable;
  - all other bits read 0.

Synchronisation
- i_io_sw and i_io_btn each pass through SYNC_STAGES flops.
- A switch change is visible at SW exactly SYNC_STAGES cycles later.

Debounce (per button)
- Each button has a counter compared against its stable bit.
- When the synced value equals the stable value, the counter is cleared.
- Otherwise the counter increments. When it reaches DB_CYCLES-1, the stable bit takes the synced value on that edge and the counter clears.
- A glitch shorter than DB_CYCLES cycles never changes the stable value.
- Total latency from raw input to BTN is SYNC_STAGES + DB_CYCLES cycles.

Edge capture
- A stable 0->1 transition sets the matching BTNEDGE bit.
- Writing 1 to a BTNEDGE bit clears it; writing 0 has no effect.
- If a set and a clear hit the same bit on the same edge, the set wins.

Timer
- With en=1, TCOUNT increments by 1 per cycle and wraps 0xFFFFFFFF->0.
- When TCOUNT == TCMP on an edge with en=1:
  - the match flag sets (sticky);
  - the next TCOUNT value is 0 if auto_reload=1, otherwise TCOUNT+1.
- A bus write to TCOUNT overrides the increment and the reload on that edge.
- Clearing the match flag by W1C and a new match on the same edge leaves the flag set.
- With en=0, TCOUNT holds its value and no match is detected.

Interrupt
- o_irq = |(BTNEDGE & btn_irq_en) | (match & timer irq_en).
- It is registered-state based only: no combinational path from bus inputs.

Test Plan:
1. Reset, then store 0xA5A5A5A5 to 0x00 with i_bmask=4'b0011 -> o_io_ledr=0x0000A5A5, and reading 0x00 returns 0x0000A5A5.
2. NUM_HEX=6: store 0x7F7F7F7F to 0x0C -> o_io_hex digits 4 and 5 = 7'h7F, and reading 0x0C returns 0x00007F7F.
3. Button 2 driven high for 3 cycles, then low -> BTN and BTNEDGE stay 0. Held high 10 cycles -> BTN[2]=1 exactly 6 cycles after the rise and BTNEDGE=0x4. Write 0x4 to 0x1C -> BTNEDGE=0.
4. TCMP=5, TCTRL=0x7 -> match sets when TCOUNT=5, TCOUNT then reads 0,1,2..., and o_irq=1. Write 0x8 to TCTRL -> o_irq=0.
5. TCTRL en only (0x1), TCOUNT=0xFFFFFFFE, TCMP=0xFFFFFFFF -> the count wraps to 0 and match sets once.
6. i_rst asserted mid-count while a button is debouncing -> the next edge gives all registers and outputs 0 and o_irq=0, and the simultaneous write is dropped.

Source files
------------

// File: rtl/mmio_io_ctrl_if.sv
// Core-side load/store bus into the IO region: word address, byte-masked store, combinational read.
interface mmio_io_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        bmask;
  logic              wren;
  logic [31:0]       rdata;

  modport master (output addr, output wdata, output bmask, output wren, input rdata);
  modport slave  (input addr, input wdata, input bmask, input wren, output rdata);
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped IO register bank: LEDs, HEX digits, LCD, synchronised switches,
// debounced buttons with sticky press flags, interval timer and a combined interrupt.
module mmio_io_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int NUM_HEX     = 8,
  parameter int NUM_BTN     = 4,
  parameter int SW_W        = 32,
  parameter int DB_CYCLES   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  mmio_io_ctrl_if.slave        bus,
  input  logic [SW_W-1:0]      i_io_sw,
  input  logic [NUM_BTN-1:0]   i_io_btn,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [31:0]          o_io_lcd,
  output logic [NUM_HEX*7-1:0] o_io_hex,
  output logic                 o_irq
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int CNT_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [WORD_W-1:0] W_LEDR   = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_LEDG   = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_HEXLO  = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_HEXHI  = WORD_W'(3);
  localparam logic [WORD_W-1:0] W_LCD    = WORD_W'(4);
  localparam logic [WORD_W-1:0] W_SW     = WORD_W'(5);
  localparam logic [WORD_W-1:0] W_BTN    = WORD_W'(6);
  localparam logic [WORD_W-1:0] W_BEDGE  = WORD_W'(7);
  localparam logic [WORD_W-1:0] W_TCOUNT = WORD_W'(8);
  localparam logic [WORD_W-1:0] W_TCMP   = WORD_W'(9);
  localparam logic [WORD_W-1:0] W_TCTRL  = WORD_W'(10);

  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
  logic [31:0] tcount_q, tcount_d, tcmp_q, tcmp_d;
  logic [NUM_HEX-1:0][6:0] hex_q, hex_d;
  logic [SYNC_STAGES-1:0][SW_W-1:0]    sw_sync_q, sw_sync_d;
  logic [SYNC_STAGES-1:0][NUM_BTN-1:0] btn_sync_q, btn_sync_d;
  logic [NUM_BTN-1:0][CNT_W-1:0]       db_cnt_q, db_cnt_d;
  logic [NUM_BTN-1:0] btn_q, btn_d, btn_edge_q, btn_edge_d, btn_ie_q, btn_ie_d;
  logic t_en_q, t_en_d, t_reload_q, t_reload_d, t_ie_q, t_ie_d, t_match_q, t_match_d;

  logic [WORD_W-1:0]  word;
  logic [NUM_BTN-1:0] btn_synced, btn_rise, edge_clr;
  logic [7:0][6:0]    hex_all;
  logic               t_hit;
  logic               unused_addr_bits;

  assign word             = bus.addr[ADDR_W-1:2];
  assign unused_addr_bits = ^bus.addr[1:0];
  assign btn_synced       = btn_sync_q[SYNC_STAGES-1];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] mask);
    logic [31:0] r;
    r = old_v;
    for (int n = 0; n < 4; n++) begin
      if (mask[n]) r[8*n +: 8] = new_v[8*n +: 8];
    end
    return r;
  endfunction

  always_comb begin
    hex_all = '0;
    hex_all[NUM_HEX-1:0] = hex_q;
  end

  always_comb begin
    ledr_d     = ledr_q;
    ledg_d     = ledg_q;
    lcd_d      = lcd_q;
    tcmp_d     = tcmp_q;
    tcount_d   = tcount_q;
    hex_d      = hex_q;
    btn_d      = btn_q;
    db_cnt_d   = db_cnt_q;
    btn_ie_d   = btn_ie_q;
    t_en_d     = t_en_q;
    t_reload_d = t_reload_q;
    t_ie_d     = t_ie_q;
    sw_sync_d  = {sw_sync_q[SYNC_STAGES-2:0], i_io_sw};
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], i_io_btn};

    if (bus.wren && word == W_LEDR) ledr_d = merge_bytes(ledr_q, bus.wdata, bus.bmask);
    if (bus.wren && word == W_LEDG) ledg_d = merge_bytes(ledg_q, bus.wdata, bus.bmask);
    if (bus.wren && word == W_LCD)  lcd_d  = merge_bytes(lcd_q, bus.wdata, bus.bmask);
    if (bus.wren && word == W_TCMP) tcmp_d = merge_bytes(tcmp_q, bus.wdata, bus.bmask);

    for (int k = 0; k < NUM_HEX; k++) begin
      if (bus.wren && bus.bmask[k % 4] && word == ((k < 4) ? W_HEXLO : W_HEXHI))
        hex_d[k] = bus.wdata[8*(k % 4) +: 7];
    end

    // A run of DB_CYCLES mismatching samples is needed before the stable bit flips.
    for (int b = 0; b < NUM_BTN; b++) begin
      if (btn_synced[b] == btn_q[b]) begin
        db_cnt_d[b] = '0;
      end else if (db_cnt_q[b] == CNT_LAST) begin
        btn_d[b]    = btn_synced[b];
        db_cnt_d[b] = '0;
      end else begin
        db_cnt_d[b] = db_cnt_q[b] + CNT_W'(1);
      end
    end
    btn_rise   = btn_d & ~btn_q;
    edge_clr   = (bus.wren && word == W_BEDGE && bus.bmask[0]) ? bus.wdata[NUM_BTN-1:0] : '0;
    btn_edge_d = (btn_edge_q & ~edge_clr) | btn_rise;

    t_hit = t_en_q && (tcount_q == tcmp_q);
    if (bus.wren && word == W_TCOUNT) tcount_d = merge_bytes(tcount_q, bus.wdata, bus.bmask);
    else if (t_en_q)                  tcount_d = (t_hit && t_reload_q) ? 32'd0 : tcount_q + 32'd1;

    // A fresh match on the same edge as a W1C keeps the flag set.
    t_match_d = (t_match_q & ~(bus.wren && word == W_TCTRL && bus.bmask[0] && bus.wdata[3])) | t_hit;
    if (bus.wren && word == W_TCTRL && bus.bmask[0]) begin
      t_en_d     = bus.wdata[0];
      t_reload_d = bus.wdata[1];
      t_ie_d     = bus.wdata[2];
    end
    if (bus.wren && word == W_TCTRL && bus.bmask[1]) btn_ie_d = bus.wdata[8 +: NUM_BTN];
  end

  always_comb begin
    bus.rdata = '0;
    case (word)
      W_LEDR:   bus.rdata = ledr_q;
      W_LEDG:   bus.rdata = ledg_q;
      W_HEXLO:  bus.rdata = {1'b0, hex_all[3], 1'b0, hex_all[2], 1'b0, hex_all[1], 1'b0, hex_all[0]};
      W_HEXHI:  bus.rdata = {1'b0, hex_all[7], 1'b0, hex_all[6], 1'b0, hex_all[5], 1'b0, hex_all[4]};
      W_LCD:    bus.rdata = lcd_q;
      W_SW:     bus.rdata = 32'(sw_sync_q[SYNC_STAGES-1]);
      W_BTN:    bus.rdata = 32'(btn_q);
      W_BEDGE:  bus.rdata = 32'(btn_edge_q);
      W_TCOUNT: bus.rdata = tcount_q;
      W_TCMP:   bus.rdata = tcmp_q;
      W_TCTRL: begin
        bus.rdata[0]            = t_en_q;
        bus.rdata[1]            = t_reload_q;
        bus.rdata[2]            = t_ie_q;
        bus.rdata[3]            = t_match_q;
        bus.rdata[8 +: NUM_BTN] = btn_ie_q;
      end
      default:  bus.rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ledr_q <= '0; ledg_q <= '0; lcd_q <= '0; tcount_q <= '0; tcmp_q <= '0;
      hex_q <= '0; sw_sync_q <= '0; btn_sync_q <= '0; db_cnt_q <= '0;
      btn_q <= '0; btn_edge_q <= '0; btn_ie_q <= '0;
      t_en_q <= 1'b0; t_reload_q <= 1'b0; t_ie_q <= 1'b0; t_match_q <= 1'b0;
    end else begin
      ledr_q <= ledr_d; ledg_q <= ledg_d; lcd_q <= lcd_d; tcount_q <= tcount_d; tcmp_q <= tcmp_d;
      hex_q <= hex_d; sw_sync_q <= sw_sync_d; btn_sync_q <= btn_sync_d; db_cnt_q <= db_cnt_d;
      btn_q <= btn_d; btn_edge_q <= btn_edge_d; btn_ie_q <= btn_ie_d;
      t_en_q <= t_en_d; t_reload_q <= t_reload_d; t_ie_q <= t_ie_d; t_match_q <= t_match_d;
    end
  end

  assign o_io_ledr = ledr_q;
  assign o_io_ledg = ledg_q;
  assign o_io_lcd  = lcd_q;
  assign o_io_hex  = hex_q;
  assign o_irq     = (|(btn_edge_q & btn_ie_q)) | (t_match_q & t_ie_q);

endmodule
